// File: rtl/lscnt_up_timer_if.sv
// Control/status bundle for lscnt_up_timer: preset, strobes and count-enable in,
// count, carry-out and status out.
interface lscnt_up_timer_if #(
  parameter int unsigned WIDTH = 16
);
  logic [WIDTH-1:0] d;
  logic             ld;
  logic             cil;
  logic             mode;
  logic             start;
  logic             stop;
  logic             cap;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] ql;
  logic             col;
  logic             tc;
  logic             run;
  logic [WIDTH-1:0] capq;

  modport master (
    output d, ld, cil, mode, start, stop, cap,
    input  q, ql, col, tc, run, capq
  );

  modport slave (
    input  d, ld, cil, mode, start, stop, cap,
    output q, ql, col, tc, run, capq
  );
endinterface

// File: rtl/lscnt_up_timer.sv
// Loadable up-counting timer with terminal count at all-ones, one-shot/periodic
// reload, snapshot capture and an active-low carry-out for cascading.
module lscnt_up_timer #(
  parameter int unsigned WIDTH = 16
) (
  input  logic              CLK,
  input  logic              RST,
  lscnt_up_timer_if.slave   bus
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  localparam logic [WIDTH-1:0] AllOnes = '1;
  localparam logic [WIDTH-1:0] One     = {{(WIDTH-1){1'b0}}, 1'b1};

  state_e           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic [WIDTH-1:0] capq_q, capq_d;
  logic             tc_q, tc_d;
  logic             run_q;
  logic             at_top;
  logic             term;
  logic             go;

  assign at_top = (q_q == AllOnes);
  // Terminal condition before LD/STOP arbitration; this is what the next stage sees.
  assign term   = (state_q == StRun) && !bus.cil && at_top;
  assign go     = bus.start && !bus.stop;

  always_comb begin
    state_d  = state_q;
    q_d      = q_q;
    tc_d     = 1'b0;
    reload_d = bus.ld ? bus.d : reload_q;
    capq_d   = bus.cap ? q_q : capq_q;

    case (state_q)
      StRun: begin
        if (bus.stop) begin
          state_d = StIdle;
        end else if (!bus.cil) begin
          if (!at_top) begin
            q_d = q_q + One;
          end else if (!bus.ld) begin
            // A load on the expiring edge swallows the terminal count entirely.
            tc_d = 1'b1;
            if (bus.mode) begin
              q_d = reload_q;
            end else begin
              state_d = StDone;
            end
          end
        end
      end
      StDone: begin
        if (go) begin
          state_d = StRun;
          q_d     = reload_q;
        end else if (bus.stop) begin
          state_d = StIdle;
        end
      end
      default: begin
        if (go) begin
          state_d = StRun;
          q_d     = reload_q;
        end
      end
    endcase

    if (bus.ld) begin
      q_d = bus.d;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= StIdle;
      q_q      <= '0;
      reload_q <= '0;
      capq_q   <= '0;
      tc_q     <= 1'b0;
      run_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      q_q      <= q_d;
      reload_q <= reload_d;
      capq_q   <= capq_d;
      tc_q     <= tc_d;
      run_q    <= (state_d == StRun);
    end
  end

  assign bus.q    = q_q;
  assign bus.ql   = ~q_q;
  assign bus.col  = ~term;
  assign bus.tc   = tc_q;
  assign bus.run  = run_q;
  assign bus.capq = capq_q;

endmodule

// File: tb/tb_lscnt_up_timer.sv
// Directed and randomized checks of lscnt_up_timer (WIDTH=4) against a behavioural
// model, plus a two-stage cascade counting 0x00..0xFF.
module tb_lscnt_up_timer;

  localparam int unsigned W = 4;

  logic CLK = 1'b0;
  logic RST;
  logic rst_c;

  always #5 CLK = ~CLK;

  lscnt_up_timer_if #(.WIDTH(W)) dut_if ();
  lscnt_up_timer_if #(.WIDTH(W)) lo_if ();
  lscnt_up_timer_if #(.WIDTH(W)) hi_if ();

  lscnt_up_timer #(.WIDTH(W)) u_dut (.CLK(CLK), .RST(RST),   .bus(dut_if.slave));
  lscnt_up_timer #(.WIDTH(W)) u_lo  (.CLK(CLK), .RST(rst_c), .bus(lo_if.slave));
  lscnt_up_timer #(.WIDTH(W)) u_hi  (.CLK(CLK), .RST(rst_c), .bus(hi_if.slave));

  assign hi_if.cil = lo_if.col;

  int total = 0;
  int bad   = 0;

  // Model: phase 0 = idle, 1 = counting, 2 = expired one-shot.
  int m_q, m_reload, m_capq, m_phase;
  int m_tc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model();
    int nq, nph, ntc;
    if (RST) begin
      m_q = 0; m_reload = 0; m_capq = 0; m_phase = 0; m_tc = 0;
    end else begin
      nq  = m_q;
      nph = m_phase;
      ntc = 0;
      if (dut_if.cap) m_capq = m_q;
      if (m_phase == 1) begin
        if (dut_if.stop) nph = 0;
        else if (!dut_if.cil) begin
          if (m_q != 15) nq = (m_q + 1) % 16;
          else if (!dut_if.ld) begin
            ntc = 1;
            if (dut_if.mode) nq = m_reload;
            else nph = 2;
          end
        end
      end else if (dut_if.start && !dut_if.stop) begin
        nph = 1;
        nq  = m_reload;
      end else if (m_phase == 2 && dut_if.stop) begin
        nph = 0;
      end
      if (dut_if.ld) begin
        nq       = int'(dut_if.d);
        m_reload = int'(dut_if.d);
      end
      m_q = nq; m_phase = nph; m_tc = ntc;
    end
  endtask

  task automatic check_all();
    chk("q",    32'(dut_if.q),    32'(m_q));
    chk("ql",   32'(dut_if.ql),   32'(15 - m_q));
    chk("tc",   32'(dut_if.tc),   32'(m_tc));
    chk("run",  32'(dut_if.run),  32'(m_phase == 1));
    chk("capq", 32'(dut_if.capq), 32'(m_capq));
    chk("col",  32'(dut_if.col),  32'(!(m_phase == 1 && !dut_if.cil && m_q == 15)));
  endtask

  task automatic step();
    @(posedge CLK);
    model();
    #1;
    check_all();
  endtask

  task automatic idle_inputs();
    dut_if.ld = 1'b0; dut_if.start = 1'b0; dut_if.stop = 1'b0; dut_if.cap = 1'b0;
  endtask

  initial begin
    int hi_tcs;
    int comb;

    RST = 1'b1; rst_c = 1'b1;
    dut_if.d = '0; dut_if.cil = 1'b1; dut_if.mode = 1'b0;
    idle_inputs();
    lo_if.d = '0; lo_if.ld = 1'b0; lo_if.cil = 1'b0; lo_if.mode = 1'b1;
    lo_if.start = 1'b0; lo_if.stop = 1'b0; lo_if.cap = 1'b0;
    hi_if.d = '0; hi_if.ld = 1'b0; hi_if.mode = 1'b1;
    hi_if.start = 1'b0; hi_if.stop = 1'b0; hi_if.cap = 1'b0;

    // Reset state
    step();
    chk("rst_q", 32'(dut_if.q), 32'h0);
    chk("rst_ql", 32'(dut_if.ql), 32'hF);
    chk("rst_col", 32'(dut_if.col), 32'h1);
    RST = 1'b0;

    // Periodic run from 0xC
    dut_if.mode = 1'b1; dut_if.cil = 1'b0;
    dut_if.ld = 1'b1; dut_if.d = 4'hC;
    step();
    dut_if.ld = 1'b0; dut_if.start = 1'b1;
    step();
    chk("start_q", 32'(dut_if.q), 32'hC);
    dut_if.start = 1'b0;
    for (int i = 0; i < 10; i++) step();
    chk("periodic_run", 32'(dut_if.run), 32'h1);

    // One-shot from 0xE
    dut_if.stop = 1'b1;
    step();
    dut_if.stop = 1'b0; dut_if.mode = 1'b0;
    dut_if.ld = 1'b1; dut_if.d = 4'hE; dut_if.start = 1'b1;
    step();
    chk("ldstart_q", 32'(dut_if.q), 32'hE);
    idle_inputs();
    step();
    step();
    chk("oneshot_tc", 32'(dut_if.tc), 32'h1);
    chk("oneshot_run", 32'(dut_if.run), 32'h0);
    chk("oneshot_col", 32'(dut_if.col), 32'h1);
    for (int i = 0; i < 3; i++) step();
    chk("oneshot_hold", 32'(dut_if.q), 32'hF);

    // Enable gating, periodic from 0xD
    dut_if.mode = 1'b1; dut_if.ld = 1'b1; dut_if.d = 4'hD; dut_if.start = 1'b1;
    step();
    idle_inputs();
    for (int i = 0; i < 12; i++) begin
      dut_if.cil = i[0];
      #1;
      step();
    end

    // LD on the terminal edge: no TC
    dut_if.cil = 1'b0; dut_if.ld = 1'b1; dut_if.d = 4'hE;
    step();
    dut_if.ld = 1'b0;
    step();
    chk("pre_ld_top", 32'(dut_if.q), 32'hF);
    dut_if.ld = 1'b1; dut_if.d = 4'h3;
    step();
    chk("ld_top_q", 32'(dut_if.q), 32'h3);
    chk("ld_top_tc", 32'(dut_if.tc), 32'h0);
    idle_inputs();

    // START+STOP from idle, then LD+START
    dut_if.stop = 1'b1;
    step();
    dut_if.start = 1'b1;
    step();
    chk("startstop_run", 32'(dut_if.run), 32'h0);
    dut_if.stop = 1'b0; dut_if.ld = 1'b1; dut_if.d = 4'h9;
    step();
    chk("ldstart9", 32'(dut_if.q), 32'h9);
    idle_inputs();

    // Capture at 0x5
    dut_if.stop = 1'b1;
    step();
    dut_if.stop = 1'b0; dut_if.ld = 1'b1; dut_if.d = 4'h0; dut_if.start = 1'b1;
    step();
    idle_inputs();
    for (int i = 0; i < 5; i++) step();
    dut_if.cap = 1'b1;
    step();
    dut_if.cap = 1'b0;
    for (int i = 0; i < 3; i++) step();
    chk("capq_hold", 32'(dut_if.capq), 32'h5);

    // Reset at the terminal count
    dut_if.ld = 1'b1; dut_if.d = 4'hE;
    step();
    dut_if.ld = 1'b0;
    step();
    RST = 1'b1;
    step();
    chk("midrst_q", 32'(dut_if.q), 32'h0);
    chk("midrst_tc", 32'(dut_if.tc), 32'h0);
    chk("midrst_col", 32'(dut_if.col), 32'h1);
    RST = 1'b0; dut_if.start = 1'b1;
    step();
    chk("midrst_reload", 32'(dut_if.q), 32'h0);
    dut_if.start = 1'b0;

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      RST          = ($urandom_range(63) == 0);
      dut_if.ld    = ($urandom_range(7) == 0);
      dut_if.d     = 4'($urandom_range(15));
      dut_if.start = ($urandom_range(5) == 0);
      dut_if.stop  = ($urandom_range(11) == 0);
      dut_if.cap   = ($urandom_range(7) == 0);
      dut_if.cil   = ($urandom_range(3) == 0);
      if ($urandom_range(31) == 0) dut_if.mode = ~dut_if.mode;
      #1;
      step();
    end
    RST = 1'b0;
    idle_inputs();

    // Two-stage cascade, 0x00..0xFF
    @(posedge CLK);
    #1;
    rst_c = 1'b0;
    lo_if.ld = 1'b1; lo_if.start = 1'b1;
    hi_if.ld = 1'b1; hi_if.start = 1'b1;
    @(posedge CLK);
    #1;
    lo_if.ld = 1'b0; lo_if.start = 1'b0;
    hi_if.ld = 1'b0; hi_if.start = 1'b0;
    chk("casc_start", {24'h0, hi_if.q, lo_if.q}, 32'h0);
    hi_tcs = 0;
    for (int k = 1; k <= 257; k++) begin
      @(posedge CLK);
      #1;
      comb = k % 256;
      chk("casc_count", {24'h0, hi_if.q, lo_if.q}, 32'(comb));
      chk("casc_hi_tc", 32'(hi_if.tc), 32'(comb == 0));
      if (hi_if.tc === 1'b1) hi_tcs++;
    end
    chk("casc_tc_count", 32'(hi_tcs), 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
